decoder_seq: RTL
================

DECODER_SEQ -- requirements
Module: decoder_seq

Interface
REQ-001 Parameter HOLD_CYCLES, default 4, cycles each one-hot output is held; SHALL be >= 1.
REQ-002 Parameter GAP_CYCLES, default 1, forced all-zero cycles after each hold; SHALL be >= 0.
REQ-003 clk  input  1  sole clock, all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  in_code is valid this cycle.
REQ-006 in_code  input  3  binary code to decode, 0..7.
REQ-007 in_ready  output  1  block can accept a code this cycle.
REQ-008 out  output  8  registered one-hot decode, out[in_code] set; all-zero when not driving.
REQ-009 out_valid  output  1  high exactly while out is non-zero.
REQ-010 busy  output  1  high when FSM is not IDLE or the FIFO is non-empty.

Function
REQ-011 Input buffering SHALL be a 2-entry FIFO of 3-bit codes with a registered occupancy count of 0..2.
REQ-012 in_ready SHALL equal (count != 2), derived from the registered count only.
REQ-013 Push SHALL occur on any edge with in_valid && in_ready; codes SHALL be popped in arrival order.
REQ-014 Push and pop on the same edge SHALL leave count unchanged and preserve order.
REQ-015 When full, push SHALL be refused even if a pop occurs the same edge.
REQ-016 FSM SHALL have states IDLE, DRIVE and GAP; a timer SHALL be sized to hold max(HOLD_CYCLES, GAP_CYCLES) - 1.
REQ-017 IDLE with count == 0: remain IDLE, out = 0, out_valid = 0.
REQ-018 IDLE with count != 0 at an edge: pop the head, register out = 8'b1 << code, set out_valid = 1, load timer = HOLD_CYCLES - 1, and enter DRIVE.
REQ-019 DRIVE at an edge: if timer != 0, decrement it and hold out.
REQ-020 DRIVE at an edge with timer == 0: clear out and out_valid; if GAP_CYCLES > 0, load timer = GAP_CYCLES - 1 and enter GAP, else enter IDLE.
REQ-021 GAP at an edge: if timer != 0, decrement it; else enter IDLE; out SHALL stay 0 throughout GAP.
REQ-022 Latency: a code pushed at edge k into an empty FIFO with the FSM in IDLE SHALL appear on out from edge k+1 to edge k+HOLD_CYCLES, and clear at edge k+HOLD_CYCLES+1.
REQ-023 Streaming period with a non-empty FIFO SHALL be HOLD_CYCLES + GAP_CYCLES + 1 cycles per code, including the one IDLE cycle.
REQ-024 A code pushed on the same edge the FSM is in IDLE with count == 0 SHALL NOT be popped on that edge.
REQ-025 out SHALL never have more than one bit set, and SHALL be glitch-free because it is driven directly from a register.

Reset
REQ-026 rst_n low SHALL asynchronously force: state IDLE, FIFO empty (count 0), timer 0, out = 8'h00, out_valid = 0.
REQ-027 During reset, in_ready SHALL be 1 and busy SHALL be 0.
REQ-028 Reset asserted mid-DRIVE or mid-GAP SHALL abort the operation; buffered codes SHALL be discarded and never output.
REQ-029 After rst_n deasserts, the first push SHALL behave per REQ-022.

Verification (HOLD_CYCLES=4, GAP_CYCLES=1 unless stated)
REQ-030 Single code: push in_code=3'b101 at edge 0 -> out=8'b00100000 and out_valid=1 after edges 1..4; out=0 at edge 5; GAP at edge 5; IDLE at edge 6; busy=0 from edge 6.
REQ-031 Full sweep: codes 0..7 streamed with in_valid held -> out sequence 01,02,04,08,10,20,40,80 (hex), each held 4 cycles, period 6 cycles; in_ready drops whenever count=2.
REQ-032 Backpressure: push 3'd1, 3'd2, 3'd3 on consecutive edges while the FSM is idle ->
- 3'd1 popped at the edge after its push;
- 3'd2 and 3'd3 buffered;
- in_ready=0 once count=2, with the next push stalled until the 3'd2 pop;
- no code lost or reordered.
REQ-033 Reset mid-operation: assert rst_n low during DRIVE of 3'd6 with 2 codes buffered -> out=0 and out_valid=0 immediately, without waiting for a clock edge; after release, out stays 0 with no new input.
REQ-034 GAP_CYCLES=0 build: stream 3'd0 then 3'd7 -> out=8'h01 for 4 cycles, one cycle of 0 (IDLE), then 8'h80 for 4 cycles.
REQ-035 Simultaneous push/pop at count=1: count stays 1 and the next output is the older code.

Source files
------------

// File: rtl/decoder_seq.sv
// ---------------------------------------------------------------------------
// decoder_seq
//
// Sequenced 3-to-8 one-hot decoder. Incoming binary codes are buffered in a
// two-entry FIFO and then presented one at a time on a registered one-hot
// output. Each code is held for HOLD_CYCLES cycles, followed by GAP_CYCLES
// forced all-zero cycles and one IDLE cycle before the next code is taken.
//
// Parameters
//   HOLD_CYCLES  cycles each one-hot value is held on out (>= 1)
//   GAP_CYCLES   all-zero cycles inserted after each hold (>= 0)
//
// Ports
//   clk        sole clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   in_code carries a code this cycle
//   in_code    3-bit binary code to decode
//   in_ready   FIFO can accept a code this cycle
//   out        registered one-hot decode, zero when not driving
//   out_valid  high exactly while out is non-zero
//   busy       FSM not idle or FIFO holds at least one code
// ---------------------------------------------------------------------------
module decoder_seq #(
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [2:0] in_code,
  output logic       in_ready,
  output logic [7:0] out,
  output logic       out_valid,
  output logic       busy
);

  // The timer must reach max(HOLD_CYCLES, GAP_CYCLES) - 1; clog2 of the
  // maximum gives exactly enough bits for that value, with a floor of one bit.
  localparam int MAX_CYCLES = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int TIMER_W    = (MAX_CYCLES <= 2) ? 1 : $clog2(MAX_CYCLES);

  localparam logic [TIMER_W-1:0] HOLD_LOAD = TIMER_W'(HOLD_CYCLES - 1);
  localparam logic [TIMER_W-1:0] GAP_LOAD  = TIMER_W'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t               state;
  logic [TIMER_W-1:0]   timer;

  logic [2:0]           fifo_mem [2];
  logic                 wr_ptr;
  logic                 rd_ptr;
  logic [1:0]           count;

  logic                 push;
  logic                 pop;
  logic [2:0]           head;

  // in_ready depends only on the registered count, so a pop on the same edge
  // never opens room for a push while the FIFO is full.
  assign in_ready = (count != 2'd2);
  assign push     = in_valid && in_ready;

  // A code is only popped from IDLE and only when the registered count is
  // non-zero, so a code pushed into an empty FIFO waits one edge.
  assign pop      = (state == IDLE) && (count != 2'd0);
  assign head     = fifo_mem[rd_ptr];

  assign busy     = (state != IDLE) || (count != 2'd0);

  // Storage carries no reset: an entry is never read unless count says it was
  // written since the last reset.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= in_code;
    end
  end

  // Pointers and occupancy. Simultaneous push and pop moves both pointers and
  // leaves the count unchanged, which keeps arrival order intact.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        wr_ptr <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Sequencer: IDLE takes the FIFO head and starts driving it, DRIVE counts
  // down the hold time, GAP counts down the forced-zero time. out and
  // out_valid are registered here so out is glitch-free and always one-hot
  // or zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      timer     <= '0;
      out       <= 8'h00;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (count != 2'd0) begin
            out       <= 8'd1 << head;
            out_valid <= 1'b1;
            timer     <= HOLD_LOAD;
            state     <= DRIVE;
          end
        end

        DRIVE: begin
          if (timer != '0) begin
            timer <= timer - 1'b1;
          end else begin
            out       <= 8'h00;
            out_valid <= 1'b0;
            if (GAP_CYCLES > 0) begin
              timer <= GAP_LOAD;
              state <= GAP;
            end else begin
              state <= IDLE;
            end
          end
        end

        GAP: begin
          if (timer != '0) begin
            timer <= timer - 1'b1;
          end else begin
            state <= IDLE;
          end
        end

        default: begin
          state     <= IDLE;
          timer     <= '0;
          out       <= 8'h00;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
